// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI4 read master among NUM_REQ
// read clients. One AR in flight at a time; an in-order tag FIFO of granted
// requester indices steers returning R beats to the oldest outstanding owner.
module axi_rd_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned IDX_W           = 2,
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                               gt_txusrclk,
    input  logic                               peripheral_reset,
    input  logic [NUM_REQ*ADDR_W-1:0]          req_araddr,
    input  logic [NUM_REQ*8-1:0]               req_arlen,
    input  logic [NUM_REQ-1:0]                 req_arvalid,
    output logic [NUM_REQ-1:0]                 req_arready,
    output logic [DATA_W-1:0]                  req_rdata,
    output logic                               req_rlast,
    output logic [NUM_REQ-1:0]                 req_rvalid,
    input  logic [NUM_REQ-1:0]                 req_rready,
    output logic                               M_AXI_ARID,
    output logic [ADDR_W-1:0]                  M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [DATA_W-1:0]                  M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               rresp_err,
    output logic                               proto_err
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic [7:0]         arlen_q, arlen_d;
    logic               arvalid_q, arvalid_d;
    logic [IDX_W-1:0]   tag_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0]   tag_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rresp_err_q, rresp_err_d;
    logic               proto_err_q, proto_err_d;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [7:0]         len_arr  [NUM_REQ];
    logic [IDX_W-1:0]   winner, cand, head;
    logic               found, grant, nonempty, rready_int, pop;

    // Unpack the flat per-requester address/length buses.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_araddr[i*ADDR_W +: ADDR_W];
            len_arr[i]  = req_arlen[i*8 +: 8];
        end
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        winner = last_grant_q;
        cand   = last_grant_q;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_grant_q) + i) % NUM_REQ);
            if (!found && req_arvalid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Grant and R-channel routing; grant is masked by reset so req_arready
    // drops immediately with the asynchronous reset.
    always_comb begin
        grant       = (state_q == S_IDLE) && found && (count_q < MAX_CNT) && !peripheral_reset;
        req_arready = '0;
        req_arready[winner] = grant;
        nonempty    = (count_q != '0);
        head        = tag_q[rd_ptr_q];
        req_rvalid  = '0;
        req_rvalid[head] = M_AXI_RVALID & nonempty;
        rready_int  = nonempty & req_rready[head];
        pop         = M_AXI_RVALID & rready_int & M_AXI_RLAST;
    end

    // AR FSM, tag FIFO bookkeeping and sticky error flags.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rresp_err_d  = rresp_err_q | (M_AXI_RVALID & rready_int & (M_AXI_RRESP != 2'b00));
        proto_err_d  = proto_err_q | (M_AXI_RVALID & ~nonempty);

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    araddr_d     = addr_arr[winner];
                    arlen_d      = len_arr[winner];
                    arvalid_d    = 1'b1;
                    last_grant_d = winner;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant) begin
            tag_d[wr_ptr_q] = winner;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (grant && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !grant) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge gt_txusrclk or posedge peripheral_reset) begin
        if (peripheral_reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rresp_err_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rresp_err_q  <= rresp_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARSIZE  = 3'b110;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_int;
    assign req_rdata     = M_AXI_RDATA;
    assign req_rlast     = M_AXI_RLAST;
    assign outstanding   = count_q;
    assign rresp_err     = rresp_err_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: inputs driven at the falling edge,
// outputs checked 1ns later with immediate assertions.
module tb_axi_rd_arbiter;

    logic           clk = 1'b0;
    logic           rst;
    logic [255:0]   req_araddr;
    logic [31:0]    req_arlen;
    logic [3:0]     req_arvalid;
    logic [3:0]     req_arready;
    logic [511:0]   req_rdata;
    logic           req_rlast;
    logic [3:0]     req_rvalid;
    logic [3:0]     req_rready;
    logic           M_AXI_ARID;
    logic [63:0]    M_AXI_ARADDR;
    logic [7:0]     M_AXI_ARLEN;
    logic [2:0]     M_AXI_ARSIZE;
    logic [1:0]     M_AXI_ARBURST;
    logic           M_AXI_ARVALID;
    logic           M_AXI_ARREADY;
    logic [511:0]   M_AXI_RDATA;
    logic [1:0]     M_AXI_RRESP;
    logic           M_AXI_RLAST;
    logic           M_AXI_RVALID;
    logic           M_AXI_RREADY;
    logic [3:0]     outstanding;
    logic           rresp_err;
    logic           proto_err;

    int total = 0;
    int bad   = 0;

    logic [63:0] a_addr [4];
    logic [7:0]  a_len  [4];

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .NUM_REQ(4), .IDX_W(2), .ADDR_W(64), .DATA_W(512), .MAX_OUTSTANDING(8)
    ) dut (
        .gt_txusrclk(clk), .peripheral_reset(rst),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arvalid(req_arvalid),
        .req_arready(req_arready), .req_rdata(req_rdata), .req_rlast(req_rlast),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .outstanding(outstanding), .rresp_err(rresp_err), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req_araddr[i*64 +: 64] = a_addr[i];
            req_arlen[i*8 +: 8]    = a_len[i];
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr[i] = 64'h0000_0001_0000_0000 + 64'(i) * 64'h1000;
            a_len[i]  = 8'h10 + 8'(i);
        end
        apply();
        req_arvalid   = '0;
        req_rready    = 4'hF;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RLAST   = 1'b0;
        M_AXI_RVALID  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Called just after a falling edge in an IDLE cycle; returns in the ISSUE cycle.
    task automatic grant_step(input int w, input int exp_out);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        #1;
        chk("grant_arready", 64'(req_arready), 64'(oh));
        tick();
        #1;
        chk("issue_arready", 64'(req_arready), 64'd0);
        chk("issue_arvalid", 64'(M_AXI_ARVALID), 64'd1);
        chk("issue_araddr", M_AXI_ARADDR, a_addr[w]);
        chk("issue_arlen", 64'(M_AXI_ARLEN), 64'(a_len[w]));
        chk("issue_outstanding", 64'(outstanding), 64'(exp_out));
    endtask

    task automatic beat(input logic [63:0] d, input logic last, input logic [1:0] resp,
                        input logic [3:0] rr, input logic [3:0] exp_rv,
                        input logic exp_rr, input int exp_out);
        tick();
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = '0;
        M_AXI_RDATA[63:0] = d;
        M_AXI_RLAST  = last;
        M_AXI_RRESP  = resp;
        req_rready   = rr;
        #1;
        chk("beat_rvalid", 64'(req_rvalid), 64'(exp_rv));
        chk("beat_rready", 64'(M_AXI_RREADY), 64'(exp_rr));
        chk("beat_rdata", req_rdata[63:0], d);
        chk("beat_rlast", 64'(req_rlast), 64'(last));
        chk("beat_outstanding", 64'(outstanding), 64'(exp_out));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord_a [5];
        int ord_b [7];
        int ord_c [7];
        ord_a = '{0, 1, 2, 3, 0};
        ord_b = '{0, 1, 2, 3, 0, 1, 3};
        ord_c = '{1, 2, 3, 0, 1, 2, 3};

        // Reset state
        rst = 1'b1;
        req_araddr = '0; req_arlen = '0; req_arvalid = '0; req_rready = 4'hF;
        M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
        M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
        tick(); #1;
        chk("rst_arready", 64'(req_arready), 64'd0);
        chk("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        chk("rst_araddr", M_AXI_ARADDR, 64'd0);
        chk("rst_arlen", 64'(M_AXI_ARLEN), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_rresp_err", 64'(rresp_err), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_arid", 64'(M_AXI_ARID), 64'd0);

        // Single request from req1, 4 beats
        do_reset();
        tick();
        a_addr[1] = 64'h1000; a_len[1] = 8'd3; apply();
        M_AXI_ARREADY = 1'b1;
        req_arvalid = 4'b0010;
        #1 chk("t1_outstanding0", 64'(outstanding), 64'd0);
        grant_step(1, 1);
        chk("t1_arsize", 64'(M_AXI_ARSIZE), 64'd6);
        chk("t1_arburst", 64'(M_AXI_ARBURST), 64'd1);
        req_arvalid = '0;
        for (int b = 0; b < 4; b++)
            beat(64'hA0 + 64'(b), (b == 3), 2'b00, 4'hF, 4'b0010, 1'b1, 1);
        tick(); M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; #1;
        chk("t1_outstanding_end", 64'(outstanding), 64'd0);
        chk("t1_rvalid_end", 64'(req_rvalid), 64'd0);
        chk("t1_arvalid_end", 64'(M_AXI_ARVALID), 64'd0);

        // All requesters valid: 0,1,2,3,0
        do_reset();
        M_AXI_ARREADY = 1'b1;
        tick(); req_arvalid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) tick();
            grant_step(ord_a[k], k + 1);
        end

        // req2 drops after three grants: 0,1,2 then 3,0,1,3
        do_reset();
        M_AXI_ARREADY = 1'b1;
        tick(); req_arvalid = 4'hF;
        for (int k = 0; k < 7; k++) begin
            if (k != 0) tick();
            grant_step(ord_b[k], k + 1);
            if (k == 2) req_arvalid = 4'b1011;
        end

        // ARREADY stalled 20 cycles, then fill to 8 outstanding
        do_reset();
        tick(); req_arvalid = 4'hF;
        grant_step(0, 1);
        for (int c = 0; c < 20; c++) begin
            tick(); #1;
            chk("stall_arvalid", 64'(M_AXI_ARVALID), 64'd1);
            chk("stall_araddr", M_AXI_ARADDR, a_addr[0]);
            chk("stall_arready", 64'(req_arready), 64'd0);
        end
        M_AXI_ARREADY = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            grant_step(ord_c[k], k + 2);
        end
        for (int c = 0; c < 4; c++) begin
            tick(); #1;
            chk("full_arready", 64'(req_arready), 64'd0);
            chk("full_outstanding", 64'(outstanding), 64'd8);
        end
        tick(); M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; #1;
        chk("full_pop_rvalid", 64'(req_rvalid), 64'b0001);
        chk("full_pop_arready", 64'(req_arready), 64'd0);
        tick(); #1;
        chk("after_pop_arready", 64'(req_arready), 64'b0001);
        chk("after_pop_outstanding", 64'(outstanding), 64'd7);
        chk("after_pop_rvalid", 64'(req_rvalid), 64'b0010);
        tick(); M_AXI_RLAST = 1'b0; #1;
        chk("push_pop_outstanding", 64'(outstanding), 64'd7);
        chk("push_pop_arvalid", 64'(M_AXI_ARVALID), 64'd1);
        chk("push_pop_head", 64'(req_rvalid), 64'b0100);
        chk("push_pop_arready", 64'(req_arready), 64'd0);
        tick(); M_AXI_RVALID = 1'b0; req_arvalid = '0;

        // Interleaved bursts req0 len1, req3 len0, req0 len2
        do_reset();
        M_AXI_ARREADY = 1'b1;
        tick();
        a_len[0] = 8'd1; a_len[3] = 8'd0; apply();
        req_arvalid = 4'b0001;
        grant_step(0, 1);
        req_arvalid = 4'b1000;
        tick();
        grant_step(3, 2);
        a_len[0] = 8'd2; apply();
        req_arvalid = 4'b0001;
        tick();
        grant_step(0, 3);
        req_arvalid = '0;
        beat(64'h10, 1'b0, 2'b00, 4'hF, 4'b0001, 1'b1, 3);
        beat(64'h11, 1'b1, 2'b00, 4'hF, 4'b0001, 1'b1, 3);
        for (int c = 0; c < 5; c++)
            beat(64'h20, 1'b1, 2'b00, 4'b0111, 4'b1000, 1'b0, 2);
        beat(64'h20, 1'b1, 2'b00, 4'hF, 4'b1000, 1'b1, 2);
        beat(64'h30, 1'b0, 2'b00, 4'hF, 4'b0001, 1'b1, 1);
        beat(64'h31, 1'b0, 2'b00, 4'hF, 4'b0001, 1'b1, 1);
        beat(64'h32, 1'b1, 2'b00, 4'hF, 4'b0001, 1'b1, 1);
        tick(); M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; #1;
        chk("il_outstanding_end", 64'(outstanding), 64'd0);

        // RRESP error on beat 2, then RVALID with nothing outstanding
        do_reset();
        M_AXI_ARREADY = 1'b1;
        tick(); req_arvalid = 4'b0100;
        grant_step(2, 1);
        req_arvalid = '0;
        for (int b = 0; b < 4; b++) begin
            beat(64'hBEEF_0000 + 64'(b), (b == 3), (b == 2) ? 2'b10 : 2'b00,
                 4'hF, 4'b0100, 1'b1, 1);
            chk("rresp_err_timing", 64'(rresp_err), (b == 3) ? 64'd1 : 64'd0);
        end
        tick(); M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00; #1;
        chk("rresp_err_held", 64'(rresp_err), 64'd1);
        chk("rresp_outstanding", 64'(outstanding), 64'd0);
        tick(); M_AXI_RVALID = 1'b1; #1;
        chk("proto_rready", 64'(M_AXI_RREADY), 64'd0);
        chk("proto_rvalid", 64'(req_rvalid), 64'd0);
        chk("proto_err_before", 64'(proto_err), 64'd0);
        tick(); M_AXI_RVALID = 1'b0; #1;
        chk("proto_err_set", 64'(proto_err), 64'd1);
        repeat (3) tick();
        #1;
        chk("proto_err_sticky", 64'(proto_err), 64'd1);
        chk("rresp_err_sticky", 64'(rresp_err), 64'd1);

        // Reset mid-burst with 3 outstanding and a held AR
        do_reset();
        M_AXI_ARREADY = 1'b1;
        tick(); req_arvalid = 4'b0010;
        grant_step(1, 1);
        tick(); grant_step(1, 2);
        tick(); grant_step(1, 3);
        M_AXI_ARREADY = 1'b0;
        req_arvalid = '0;
        tick(); M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b01; #1;
        chk("mid_rvalid", 64'(req_rvalid), 64'b0010);
        tick(); #1;
        chk("mid_rresp_err", 64'(rresp_err), 64'd1);
        chk("mid_outstanding", 64'(outstanding), 64'd3);
        chk("mid_arvalid", 64'(M_AXI_ARVALID), 64'd1);
        rst = 1'b1; req_arvalid = 4'hF; #1;
        chk("arst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        chk("arst_araddr", M_AXI_ARADDR, 64'd0);
        chk("arst_arlen", 64'(M_AXI_ARLEN), 64'd0);
        chk("arst_outstanding", 64'(outstanding), 64'd0);
        chk("arst_rvalid", 64'(req_rvalid), 64'd0);
        chk("arst_rready", 64'(M_AXI_RREADY), 64'd0);
        chk("arst_rresp_err", 64'(rresp_err), 64'd0);
        chk("arst_arready", 64'(req_arready), 64'd0);
        tick(); M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; rst = 1'b0; #1;
        chk("post_rst_arready", 64'(req_arready), 64'b0001);
        chk("post_rst_proto_err", 64'(proto_err), 64'd0);
        tick(); #1;
        chk("post_rst_arvalid", 64'(M_AXI_ARVALID), 64'd1);
        chk("post_rst_araddr", M_AXI_ARADDR, a_addr[0]);
        chk("post_rst_outstanding", 64'(outstanding), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
